// File: rtl/beat_pattern_gen.sv
// Beatmap note-value generator: start/stop/step sequence in wrap, ping-pong or one-shot mode.
// Define BEAT_PATTERN_GEN_RANDOM_EN to turn mode 3 into an LFSR-driven random mode.
module beat_pattern_gen #(
    parameter int                DATA_W   = 8,
    parameter logic [DATA_W-1:0] START    = DATA_W'(120),
    parameter logic [DATA_W-1:0] STOP     = DATA_W'(136),
    parameter logic [DATA_W-1:0] STEP     = DATA_W'(4),
    parameter logic [1:0]        MODE     = 2'd0,
    parameter int                TICK_DIV = 1
`ifdef BEAT_PATTERN_GEN_RANDOM_EN
    ,
    parameter logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(8'hB8)
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              cfg_load,
    input  logic [DATA_W-1:0] cfg_start,
    input  logic [DATA_W-1:0] cfg_stop,
    input  logic [DATA_W-1:0] cfg_step,
    input  logic [1:0]        cfg_mode,
    output logic              data_valid,
    input  logic              data_ready,
    output logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              done,
    output logic              wrap_pulse,
    output logic              overrun
);

    localparam int DIV_W = $clog2(TICK_DIV) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] M_PING = 2'd1;
    localparam logic [1:0] M_ONE  = 2'd2;
`ifdef BEAT_PATTERN_GEN_RANDOM_EN
    localparam logic [1:0] M_RAND = 2'd3;
`endif

    logic [1:0]        state;
    logic [DATA_W-1:0] act_start;
    logic [DATA_W-1:0] act_stop;
    logic [DATA_W-1:0] act_step;
    logic [1:0]        act_mode;
    logic              dir_down;
    logic [DIV_W-1:0]  cnt;

    logic              running;
    logic              tick;
    logic              xfer;
    logic [DATA_W-1:0] eff_stop;
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   diff;
    logic [DATA_W:0]   low_edge;
    logic              over;
    logic [DATA_W-1:0] nxt;
    logic              nxt_dir;
    logic              nxt_wrap;
    logic              terminal;

`ifdef BEAT_PATTERN_GEN_RANDOM_EN
    logic [DATA_W-1:0] lfsr;
    logic [DATA_W-1:0] lfsr_nxt;
    logic [DATA_W:0]   rnd;

    assign lfsr_nxt = lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
    assign rnd      = {1'b0, act_start} + {1'b0, lfsr};

    // Galois form with a nonzero seed never reaches the all-zero lock-up state.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= DATA_W'(1);
        end else if (running && xfer) begin
            lfsr <= lfsr_nxt;
        end
    end
`endif

    assign running = (state == S_RUN) && enable;
    assign tick    = (state == S_RUN) && (cnt == DIV_LAST);
    assign xfer    = data_valid && data_ready;
    assign busy    = (state == S_RUN);
    assign done    = (state == S_DONE);

    // start > stop collapses the range onto start, giving a constant stream.
    assign eff_stop = (act_start > act_stop) ? act_start : act_stop;
    assign sum      = {1'b0, data} + {1'b0, act_step};
    assign diff     = {1'b0, data} - {1'b0, act_step};
    assign low_edge = {1'b0, act_start} + {1'b0, act_step};
    assign over     = sum > {1'b0, eff_stop};

    always_comb begin
        nxt      = sum[DATA_W-1:0];
        nxt_dir  = dir_down;
        nxt_wrap = 1'b0;
        terminal = 1'b0;
        case (act_mode)
            M_PING: begin
                if (!dir_down) begin
                    if (over) begin
                        nxt_dir  = 1'b1;
                        nxt_wrap = 1'b1;
                        if (diff[DATA_W] || (diff[DATA_W-1:0] < act_start)) begin
                            nxt = act_start;
                        end else begin
                            nxt = diff[DATA_W-1:0];
                        end
                    end
                end else if ({1'b0, data} < low_edge) begin
                    nxt_dir  = 1'b0;
                    nxt_wrap = 1'b1;
                    nxt      = over ? eff_stop : sum[DATA_W-1:0];
                end else begin
                    nxt = diff[DATA_W-1:0];
                end
            end
            M_ONE: begin
                if (over) begin
                    terminal = 1'b1;
                    nxt      = data;
                end
            end
`ifdef BEAT_PATTERN_GEN_RANDOM_EN
            M_RAND: begin
                nxt = (rnd > {1'b0, eff_stop}) ? eff_stop : rnd[DATA_W-1:0];
            end
`endif
            default: begin
                if (over) begin
                    nxt      = act_start;
                    nxt_wrap = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            act_start  <= START;
            act_stop   <= STOP;
            act_step   <= STEP;
            act_mode   <= MODE;
            dir_down   <= 1'b0;
            cnt        <= '0;
            data       <= START;
            data_valid <= 1'b0;
            wrap_pulse <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            wrap_pulse <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    data_valid <= 1'b0;
                    if (cfg_load) begin
                        act_start <= cfg_start;
                        act_stop  <= cfg_stop;
                        act_step  <= cfg_step;
                        act_mode  <= cfg_mode;
                        overrun   <= 1'b0;
                    end
                    if (state == S_DONE) begin
                        if (!enable) begin
                            state <= S_IDLE;
                        end
                    end else if (enable) begin
                        state      <= S_RUN;
                        data       <= cfg_load ? cfg_start : act_start;
                        data_valid <= 1'b1;
                        dir_down   <= 1'b0;
                        cnt        <= '0;
                    end
                end
                S_RUN: begin
                    if (!enable) begin
                        state      <= S_IDLE;
                        data_valid <= 1'b0;
                    end else begin
                        cnt <= tick ? '0 : cnt + DIV_W'(1);
                        if (xfer && terminal) begin
                            state      <= S_DONE;
                            data_valid <= 1'b0;
                        end else begin
                            if (xfer) begin
                                data       <= nxt;
                                dir_down   <= nxt_dir;
                                wrap_pulse <= nxt_wrap;
                            end
                            data_valid <= tick || (data_valid && !xfer);
                            // The held sample is never dropped; the missed tick is only flagged.
                            if (tick && data_valid && !xfer) begin
                                overrun <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    data_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_beat_pattern_gen.sv
// Directed bench for beat_pattern_gen: one instance at TICK_DIV=1, one at TICK_DIV=4.
module tb_beat_pattern_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       cfg_load;
    logic [7:0] cfg_start;
    logic [7:0] cfg_stop;
    logic [7:0] cfg_step;
    logic [1:0] cfg_mode;
    logic       data_ready;

    logic       a_valid, a_busy, a_done, a_wrap, a_ovr;
    logic [7:0] a_data;
    logic       b_valid, b_busy, b_done, b_wrap, b_ovr;
    logic [7:0] b_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    beat_pattern_gen #(.TICK_DIV(1)) u_a (
        .clk(clk), .reset(reset), .enable(enable), .cfg_load(cfg_load),
        .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_step(cfg_step),
        .cfg_mode(cfg_mode), .data_valid(a_valid), .data_ready(data_ready),
        .data(a_data), .busy(a_busy), .done(a_done), .wrap_pulse(a_wrap),
        .overrun(a_ovr)
    );

    beat_pattern_gen #(.TICK_DIV(4)) u_b (
        .clk(clk), .reset(reset), .enable(enable), .cfg_load(cfg_load),
        .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_step(cfg_step),
        .cfg_mode(cfg_mode), .data_valid(b_valid), .data_ready(data_ready),
        .data(b_data), .busy(b_busy), .done(b_done), .wrap_pulse(b_wrap),
        .overrun(b_ovr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input int s, input int e, input int st, input int m);
        cfg_start = 8'(s);
        cfg_stop  = 8'(e);
        cfg_step  = 8'(st);
        cfg_mode  = 2'(m);
        cfg_load  = 1'b1;
    endtask

    int seq1_d[7] = '{120, 124, 128, 132, 136, 120, 124};
    int seq1_w[7] = '{0, 0, 0, 0, 0, 1, 0};
    int seq2_d[6] = '{10, 15, 20, 15, 10, 15};
    int seq2_w[6] = '{0, 0, 0, 1, 0, 1};
    int seq3_d[3] = '{0, 4, 8};

    initial begin
        reset = 1'b1; enable = 1'b0; cfg_load = 1'b0; data_ready = 1'b0;
        cfg_start = '0; cfg_stop = '0; cfg_step = '0; cfg_mode = '0;
        step(2);
        chk("rst_data", a_data, 120);
        chk("rst_valid", a_valid, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_wrap", a_wrap, 0);
        chk("rst_ovr", a_ovr, 0);
        chk("rst_b_data", b_data, 120);

        // default wrap sequence, one value per cycle
        reset = 1'b0; enable = 1'b1; data_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            chk($sformatf("wrap_data%0d", i), a_data, 32'(seq1_d[i]));
            chk($sformatf("wrap_pulse%0d", i), a_wrap, 32'(seq1_w[i]));
        end
        chk("wrap_valid", a_valid, 1);
        chk("wrap_ovr", a_ovr, 0);

        // load while running is ignored
        load(0, 9, 0, 0);
        step();
        chk("run_load_ign", a_data, 128);
        cfg_load = 1'b0;

        // reset mid-run at 128
        reset = 1'b1;
        step();
        chk("midrst_data", a_data, 120);
        chk("midrst_valid", a_valid, 0);
        chk("midrst_busy", a_busy, 0);
        reset = 1'b0;
        step();
        chk("rerun_data0", a_data, 120);
        chk("rerun_valid", a_valid, 1);
        step();
        chk("rerun_data1", a_data, 124);
        enable = 1'b0;
        step();
        chk("stop_data", a_data, 124);
        chk("stop_valid", a_valid, 0);
        chk("stop_busy", a_busy, 0);

        // ping-pong 10..20 step 5
        load(10, 20, 5, 1);
        step();
        cfg_load = 1'b0; enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("pp_data%0d", i), a_data, 32'(seq2_d[i]));
            chk($sformatf("pp_wrap%0d", i), a_wrap, 32'(seq2_w[i]));
        end
        enable = 1'b0;
        step();

        // one-shot 0..9 step 4
        load(0, 9, 4, 2);
        step();
        cfg_load = 1'b0; enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("os_data%0d", i), a_data, 32'(seq3_d[i]));
        end
        step();
        chk("os_done", a_done, 1);
        chk("os_busy", a_busy, 0);
        chk("os_valid", a_valid, 0);
        chk("os_data_hold", a_data, 8);
        step();
        chk("os_done_stay", a_done, 1);
        enable = 1'b0;
        step();
        chk("os_idle", a_done, 0);
        enable = 1'b1;
        step();
        chk("os_restart", a_data, 0);
        chk("os_restart_v", a_valid, 1);
        chk("os_restart_b", a_busy, 1);

        // step 0 gives a constant stream without wraps
        enable = 1'b0;
        step();
        load(7, 20, 0, 0);
        step();
        cfg_load = 1'b0; enable = 1'b1;
        step();
        chk("const_first", a_data, 7);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("const_data%0d", i), a_data, 7);
            chk($sformatf("const_wrap%0d", i), a_wrap, 0);
        end

        // TICK_DIV=4 instance: stalled consumer
        reset = 1'b1; enable = 1'b0; data_ready = 1'b0;
        step();
        reset = 1'b0; enable = 1'b1;
        step();
        chk("div_start_v", b_valid, 1);
        chk("div_start_d", b_data, 120);
        chk("div_start_o", b_ovr, 0);
        step(3);
        chk("div_pre_tick_o", b_ovr, 0);
        step();
        chk("div_tick_o", b_ovr, 1);
        chk("div_tick_d", b_data, 120);
        step(5);
        chk("div_hold_d", b_data, 120);
        chk("div_hold_v", b_valid, 1);
        chk("div_hold_o", b_ovr, 1);
        data_ready = 1'b1;
        step();
        chk("div_xfer_d", b_data, 124);
        chk("div_xfer_v", b_valid, 0);
        step();
        chk("div_gap_v", b_valid, 0);
        step();
        chk("div_next_v", b_valid, 1);
        chk("div_next_d", b_data, 124);
        chk("div_sticky_o", b_ovr, 1);
        enable = 1'b0; data_ready = 1'b0;
        step();
        load(0, 9, 4, 2);
        step();
        cfg_load = 1'b0;
        chk("div_ovr_clr", b_ovr, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/beat_pattern_gen.md
Name: beat_pattern_gen

Overview:
Parametrised beatmap note-value generator with runtime-loadable start/stop/step and a selectable sequence mode (wrap, ping-pong, one-shot).
- Emits one value per beat tick over a valid/ready stream; the tick comes from an internal clock divider.
- Feeds the beatmap lane/note scheduler and replaces the fixed-sequence generators with a single configurable block.

Parameters:
DATA_W, 8, width of data and config values
START, 120, reset/default start value
STOP, 136, reset/default stop value (inclusive)
STEP, 4, reset/default increment; STEP_W = DATA_W
MODE, 0, reset/default mode: 0 WRAP, 1 PINGPONG, 2 ONESHOT, 3 reserved
TICK_DIV, 1, clk cycles per beat tick (>=1); DIV_W = clog2(TICK_DIV)+1
LFSR_TAPS, 8'hB8, Galois LFSR tap mask (optional feature only)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
enable  in  1  1 = run, 0 = stop and return to IDLE
cfg_load  in  1  latch cfg_* into active config (IDLE/DONE only)
cfg_start  in  DATA_W  start value
cfg_stop  in  DATA_W  stop value
cfg_step  in  DATA_W  step size
cfg_mode  in  2  sequence mode
data_valid  out  1  data holds an unconsumed sample
data_ready  in  1  consumer accepts sample
data  out  DATA_W  current sample
busy  out  1  state == RUN
done  out  1  state == DONE
wrap_pulse  out  1  one-cycle pulse on wrap/reversal
overrun  out  1  sticky: a tick arrived while the previous sample was unconsumed

Behaviour:
- Reset (synchronous, active-high):
  - Outputs: data=START, data_valid=0, busy=0, done=0, wrap_pulse=0, overrun=0.
  - Active config reverts to START/STOP/STEP/MODE; state=IDLE; direction=up; tick counter=0.
  - Reset overrides every other input in the same cycle. A reset mid-run takes effect on the next edge.
- Config:
  - cfg_load is accepted only in IDLE or DONE; in RUN it is ignored.
  - cfg_load also clears overrun.
  - If start>stop, the block treats stop as equal to start, giving constant output.
- States:
  - IDLE -> RUN when enable=1: data<=start, data_valid<=1, direction=up, tick counter cleared.
  - RUN -> IDLE when enable=0 (checked before everything else): data_valid<=0 at the next edge with no handshake; data keeps its value.
  - RUN -> DONE on the ONESHOT terminal handshake.
  - DONE -> IDLE when enable=0. While in DONE, data_valid=0 and done=1.
- Tick:
  - In RUN, the counter increments every cycle; tick when counter==TICK_DIV-1, then the counter returns to 0.
  - TICK_DIV=1 gives a tick every cycle.
- Handshake (RUN):
  - A transfer occurs when data_valid and data_ready are both 1. On a transfer, data<=next value.
  - data_valid next cycle = tick OR (data_valid AND NOT transfer). So a transfer and a tick in the same cycle present the new value immediately; a transfer without a tick drops valid until the next tick.
  - A tick with data_valid=1 and no transfer sets overrun. The sample is held and nothing is skipped.
- Next value:
  - Computed in DATA_W+1 bits, so there is no overflow: sum = data + step.
  - WRAP: if sum > stop, next = start and wrap_pulse fires; otherwise next = sum.
  - PINGPONG up: if sum > stop, direction becomes down, next = max(data-step, start), and wrap_pulse fires.
  - PINGPONG down: if data < start+step, direction becomes up, next = min(sum, stop), and wrap_pulse fires; otherwise next = data-step.
  - ONESHOT: if sum > stop, the transfer is terminal: state -> DONE, data is unchanged, data_valid<=0. Otherwise next = sum.
  - Mode 3 behaves as WRAP.
  - step=0 gives constant output; ONESHOT then never completes.
- wrap_pulse is registered: high for exactly the one cycle after the causing transfer.

Optional Feature:
Macro BEAT_PATTERN_GEN_RANDOM_EN.
- Defined: mode 3 becomes RANDOM.
  - A DATA_W-bit Galois LFSR (taps LFSR_TAPS, reset seed 1, never 0) advances on each transfer.
  - next = start + lfsr_value, saturated to stop. wrap_pulse is never asserted in this mode.
- Not defined: no LFSR is instantiated and mode 3 behaves as WRAP.

Test Plan:
1. Defaults, TICK_DIV=1, enable=1, ready=1 -> data 120,124,128,132,136,120,... on consecutive cycles; wrap_pulse high the cycle after the 136 transfer; overrun=0.
2. cfg_load start=10 stop=20 step=5 mode=1, ready=1 -> 10,15,20,15,10,15; wrap_pulse after the 20 and 10 transfers.
3. cfg_load start=0 stop=9 step=4 mode=2 -> 0,4,8, then done=1, busy=0, data_valid=0, data=8; enable 0->1 restarts at 0.
4. TICK_DIV=4, ready=0 for 10 cycles after start -> data=120 held, data_valid=1, overrun=1 from the first tick; ready=1 -> 124 appears on the next tick.
5. Reset asserted while data=128 in RUN -> next edge data=120, data_valid=0, busy=0, config back to defaults.
6. cfg_load with step=0 during RUN -> ignored (sequence continues); then in IDLE load step=0 mode=0 -> constant start value, wrap_pulse never.
